inst_queue: RTL
===============

Name: inst_queue

Overview:
- Instruction queue between the instruction fetcher and the decoder.
- Buffers fetched {PC, instruction, predicted-branch} tuples in program order and presents the oldest entry to the decoder with a valid/ready handshake.
- Generates the registered stall back to the fetcher.
- Flushes on branch-mispredict clear from the ROB.

Parameters:
- DEPTH_LOG, 3, log2 of entry count (DEPTH = 8).
- ADDR_WIDTH, 32, PC width.
- INST_WIDTH, 32, instruction width.
- AFULL_MARGIN, 2, free slots that must remain when stall is raised; covers the fetcher's one-cycle stall reaction.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset; asynchronous, active-low.
- rdy_in  input  1  global ready; low freezes all state.
- clr_in  input  1  synchronous flush from ROB on mispredict.
- if_to_iq_valid  input  1  fetcher pushes an entry this cycle.
- if_to_iq_PC  input  ADDR_WIDTH  PC of pushed instruction.
- if_to_iq_inst  input  INST_WIDTH  pushed instruction word.
- if_to_iq_pred_br  input  1  fetcher's taken prediction.
- iq_to_if_stall  output  1  registered backpressure to fetcher.
- dc_to_iq_ready  input  1  decoder accepts head entry this cycle.
- iq_to_dc_valid  output  1  head entry present.
- iq_to_dc_PC  output  ADDR_WIDTH  head PC.
- iq_to_dc_inst  output  INST_WIDTH  head instruction.
- iq_to_dc_opType  output  7  head instruction bits [6:0].
- iq_to_dc_pred_br  output  1  head prediction bit.
- iq_count  output  DEPTH_LOG+1  current occupancy.
- iq_overflow  output  1  sticky error: push attempted while full with no pop.

Behaviour:
- Storage: DEPTH-entry circular buffer.
  - head and tail pointers are DEPTH_LOG+1 bits; the MSB is the wrap bit.
  - empty = (head == tail).
  - full = index bits equal and wrap bits differ.
  - Entry RAM is not reset.
- Reset (rst_in low, asynchronous): head = 0, tail = 0, count = 0, iq_to_if_stall = 0, iq_overflow = 0. This forces iq_to_dc_valid = 0.
- Data outputs are combinational from the head entry:
  - iq_to_dc_valid = !empty.
  - When empty, iq_to_dc_PC, iq_to_dc_inst, iq_to_dc_opType and iq_to_dc_pred_br are don't-care.
- pop = iq_to_dc_valid && dc_to_iq_ready. On pop, head increments.
- push = if_to_iq_valid && (!full || pop).
  - On push, the entry is written at tail and tail increments, wrapping modulo 2*DEPTH on the pointer.
  - Full with simultaneous pop: the push is accepted and count is unchanged.
  - Empty with simultaneous push: no bypass. The pushed entry appears at the head the next cycle; decoder latency through the queue is 1 cycle minimum.
- count_next = count + push - pop.
- Stall: iq_to_if_stall is registered as (count_next >= DEPTH - AFULL_MARGIN).
  - The fetcher may deliver one more push in the cycle after stall rises; the margin absorbs it without overflow.
- Overflow: if_to_iq_valid && full && !pop sets iq_overflow. The entry is dropped and the flag stays set until reset.
- Flush (clr_in high, rdy_in high): head = 0, tail = 0, count = 0, stall = 0.
  - Any push or pop in that cycle is ignored.
  - iq_to_dc_valid is 0 in the following cycle.
  - clr_in has priority over all other activity.
- rdy_in low: no push, no pop, no flush. All registers hold; outputs reflect the held state.
- Reset asserted mid-operation discards all entries immediately. Outputs return to reset values without waiting for a clock edge.

Test Plan:
- Reset then idle: rst_in low for 2 cycles, then high -> iq_to_dc_valid = 0, iq_count = 0, iq_to_if_stall = 0, iq_overflow = 0.
- Single pass-through: push PC = 0x0000_0010, inst = 0x0000_006F (JAL), pred = 1 with decoder ready.
  - Next cycle: valid = 1, opType = 0x6F, pred_br = 1.
  - Following cycle: valid = 0 and count returns to 0.
- Fill with backpressure: push 8 sequential PCs 0x00..0x1C with decoder not ready.
  - Stall rises in the cycle after count_next reaches 6.
  - Push 7 is still accepted; count = 8, full.
  - A 9th push asserts iq_overflow = 1 and the head stays PC 0x00.
- Full with simultaneous push/pop: with 8 entries, push PC 0x20 and pop in the same cycle -> count stays 8. Draining yields PCs 0x04..0x20 in order, exercising pointer wrap.
- Flush: with 5 entries, assert clr_in alongside a push and decoder ready -> next cycle count = 0, valid = 0, stall = 0, and no entry was consumed.
- Freeze: rdy_in low for 3 cycles while pushing and ready -> count and head unchanged. After rdy_in returns high, normal flow resumes with the original head PC.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetcher and decoder: in-order circular buffer with
// a registered almost-full stall, sticky overflow flag and synchronous flush.
module inst_queue #(
    parameter int unsigned DEPTH_LOG    = 3,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned INST_WIDTH   = 32,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,
    input  logic                  if_to_iq_valid,
    input  logic [ADDR_WIDTH-1:0] if_to_iq_PC,
    input  logic [INST_WIDTH-1:0] if_to_iq_inst,
    input  logic                  if_to_iq_pred_br,
    output logic                  iq_to_if_stall,
    input  logic                  dc_to_iq_ready,
    output logic                  iq_to_dc_valid,
    output logic [ADDR_WIDTH-1:0] iq_to_dc_PC,
    output logic [INST_WIDTH-1:0] iq_to_dc_inst,
    output logic [6:0]            iq_to_dc_opType,
    output logic                  iq_to_dc_pred_br,
    output logic [DEPTH_LOG:0]    iq_count,
    output logic                  iq_overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;
    localparam int unsigned EW    = ADDR_WIDTH + INST_WIDTH + 1;
    localparam logic [DEPTH_LOG:0] StallThresh = (DEPTH_LOG + 1)'(DEPTH - AFULL_MARGIN);

    // Entry layout: {pred_br, PC, inst}
    logic [EW-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG:0] head_q, head_d;
    logic [DEPTH_LOG:0] tail_q, tail_d;
    logic [DEPTH_LOG:0] count_q, count_d;
    logic [DEPTH_LOG:0] count_nxt;
    logic               stall_q, stall_d;
    logic               ovf_q, ovf_d;
    logic               empty, full, pop, push, wr_en;
    logic [EW-1:0]      head_entry;

    always_comb begin
        empty     = (head_q == tail_q);
        full      = (head_q[DEPTH_LOG-1:0] == tail_q[DEPTH_LOG-1:0]) &&
                    (head_q[DEPTH_LOG] != tail_q[DEPTH_LOG]);
        pop       = !empty && dc_to_iq_ready;
        push      = if_to_iq_valid && (!full || pop);
        count_nxt = count_q + (DEPTH_LOG + 1)'(push) - (DEPTH_LOG + 1)'(pop);

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stall_d = stall_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;

        if (rdy_in) begin
            if (clr_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                stall_d = 1'b0;
            end else begin
                if (push) begin
                    wr_en  = 1'b1;
                    tail_d = tail_q + 1'b1;
                end
                if (pop) begin
                    head_d = head_q + 1'b1;
                end
                count_d = count_nxt;
                stall_d = (count_nxt >= StallThresh);
                if (if_to_iq_valid && full && !pop) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage carries no reset.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_q[tail_q[DEPTH_LOG-1:0]] <= {if_to_iq_pred_br, if_to_iq_PC, if_to_iq_inst};
        end
    end

    always_comb begin
        head_entry       = mem_q[head_q[DEPTH_LOG-1:0]];
        iq_to_dc_valid   = !empty;
        iq_to_dc_inst    = head_entry[INST_WIDTH-1:0];
        iq_to_dc_PC      = head_entry[INST_WIDTH +: ADDR_WIDTH];
        iq_to_dc_pred_br = head_entry[EW-1];
        iq_to_dc_opType  = head_entry[6:0];
        iq_to_if_stall   = stall_q;
        iq_count         = count_q;
        iq_overflow      = ovf_q;
    end

endmodule
